ps_lane_arbiter: RTL and testbench

Round-robin scheduler that shares one 8-bit parallel-to-serial lane among `N_REQ` byte requesters. It sits directly upstream of the serializer, driving its `data_inP`/`valid_in` pair in the `clk_f` domain. It inserts the idle comma symbol whenever no data is scheduled. An optional post-reset comma preamble lets the far end lock before payload flows.

---
 rtl/ps_arb_pkg.sv | 22 ++
 rtl/ps_rr_picker.sv | 37 +++
 rtl/ps_lane_arbiter.sv | 151 +++++++++++++++
 tb/tb_ps_lane_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps_arb_pkg.sv
// ps_arb_pkg: shared state type, comma symbol and width helper for the ps_lane_arbiter slice.
package ps_arb_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    SERVE = 2'd2
  } arb_state_e;

  localparam logic [7:0] COMMA = 8'hBC;

  // Ceil-log2 with a one-bit floor so degenerate parameters still yield a usable field.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits++;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/ps_rr_picker.sv
// ps_rr_picker: combinational round-robin picker returning the first valid requester at or
// above ptr, wrapping at N_REQ (not at the next power of two).
module ps_rr_picker
  import ps_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   ptr,
  output logic             any,
  output logic [IDW-1:0]   idx
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // Scan offsets from farthest to nearest so the closest valid requester overwrites the rest.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    sum  = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N_REQ)) begin
        sum = sum - (IDW+1)'(N_REQ);
      end
      cand = sum[IDW-1:0];
      if (req_valid[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/ps_lane_arbiter.sv
// ps_lane_arbiter: round-robin scheduler sharing one byte lane among N_REQ requesters, commas when idle.
// Define PS_ARB_SYNC_EN to emit SYNC_LEN comma cycles after every reset before payload may flow.
module ps_lane_arbiter
  import ps_arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int BURST    = 4,
  parameter  int SYNC_LEN = 4,
  localparam int IDW      = clog2(N_REQ),
  localparam int BCW      = clog2(BURST + 1)
) (
  input  logic               clk_f,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         data_inP,
  output logic               valid_in,
  output logic [IDW-1:0]     grant_id,
  output logic               sync_done
);

`ifdef PS_ARB_SYNC_EN
  localparam int         SCW         = clog2(SYNC_LEN + 1);
  localparam arb_state_e RESET_STATE = SYNC;

  logic [SCW-1:0] sync_cnt_q, sync_cnt_d;
  logic           sync_done_q, sync_done_d;
`else
  localparam arb_state_e RESET_STATE = IDLE;

  logic unused_sync_len;
  assign unused_sync_len = (SYNC_LEN > 0);
`endif

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           serving;
  logic           xfer;
  logic [IDW-1:0] next_ptr;

  ps_rr_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .req_valid(req_valid),
    .ptr      (ptr_q),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  assign serving   = (state_q == SERVE);
  assign xfer      = serving & req_valid[grant_q];
  assign next_ptr  = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign req_ready = serving ? (N_REQ'(1) << grant_q) : '0;

  // Output byte is captured on the same edge that accepts it; otherwise the lane carries a comma.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    data_d  = xfer ? req_data[{grant_q, 3'b000} +: 8] : COMMA;
    valid_d = xfer;
`ifdef PS_ARB_SYNC_EN
    sync_cnt_d  = sync_cnt_q;
    sync_done_d = sync_done_q;
`endif
    case (state_q)
      SYNC: begin
`ifdef PS_ARB_SYNC_EN
        if (sync_cnt_q == SCW'(SYNC_LEN - 1)) begin
          state_d     = IDLE;
          sync_done_d = 1'b1;
        end else begin
          sync_cnt_d = sync_cnt_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          beat_d  = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        // A missing beat ends the burst just like a full one, so a stalled requester cannot hog the lane.
        if (xfer && (beat_q != BCW'(BURST - 1))) begin
          beat_d = beat_q + 1'b1;
        end else begin
          if (xfer) begin
            beat_d = BCW'(BURST);
          end
          ptr_d   = next_ptr;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      grant_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      data_q  <= COMMA;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef PS_ARB_SYNC_EN
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      sync_cnt_q  <= '0;
      sync_done_q <= 1'b0;
    end else begin
      sync_cnt_q  <= sync_cnt_d;
      sync_done_q <= sync_done_d;
    end
  end

  assign sync_done = sync_done_q;
`else
  assign sync_done = 1'b1;
`endif

  assign data_inP = data_q;
  assign valid_in = valid_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_ps_lane_arbiter.sv
// tb_ps_lane_arbiter: directed bench driving two arbiters (BURST 4 and 2) from one stimulus stream,
// checked every cycle against a behavioural lane model plus hand-computed literal expectations.
module tb_ps_lane_arbiter;

  localparam int N        = 4;
  localparam int SYNC_LEN = 4;
  localparam int BURST_A  = 4;
  localparam int BURST_B  = 2;
`ifdef PS_ARB_SYNC_EN
  localparam int   SYNC_OFF = SYNC_LEN;
  localparam logic SYNC_RST = 1'b0;
`else
  localparam int   SYNC_OFF = 0;
  localparam logic SYNC_RST = 1'b1;
`endif

  logic           clk_f = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;

  logic [N-1:0] ready_a, ready_b;
  logic [7:0]   data_a, data_b;
  logic         valid_a, valid_b;
  logic [1:0]   gid_a, gid_b;
  logic         sync_a, sync_b;

  int   total = 0;
  int   bad = 0;
  bit   check_en = 1'b0;
  logic [7:0] next_byte [N];

  // Model of each lane: remaining preamble, whether a burst is open, its owner, beats taken, rotation pointer.
  int         m_sync_left [2];
  bit         m_sync_done [2];
  bit         m_serving [2];
  int         m_g [2];
  int         m_beats [2];
  int         m_ptr [2];
  logic [7:0] m_data [2];
  bit         m_valid [2];
  int         m_xfer_id [2];

  always #5 clk_f = ~clk_f;

  ps_lane_arbiter #(.N_REQ(N), .BURST(BURST_A), .SYNC_LEN(SYNC_LEN)) dut_a (
    .clk_f    (clk_f),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(ready_a),
    .data_inP (data_a),
    .valid_in (valid_a),
    .grant_id (gid_a),
    .sync_done(sync_a)
  );

  ps_lane_arbiter #(.N_REQ(N), .BURST(BURST_B), .SYNC_LEN(SYNC_LEN)) dut_b (
    .clk_f    (clk_f),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(ready_b),
    .data_inP (data_b),
    .valid_in (valid_b),
    .grant_id (gid_b),
    .sync_done(sync_b)
  );

  function automatic int burst_of(input int d);
    return (d == 0) ? BURST_A : BURST_B;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int d);
    return m_serving[d] ? N'(1 << m_g[d]) : '0;
  endfunction

  task automatic model_reset(input int d);
    m_sync_left[d] = SYNC_OFF;
    m_sync_done[d] = SYNC_RST;
    m_serving[d]   = 1'b0;
    m_g[d]         = 0;
    m_beats[d]     = 0;
    m_ptr[d]       = 0;
    m_data[d]      = 8'hBC;
    m_valid[d]     = 1'b0;
    m_xfer_id[d]   = -1;
  endtask

  task automatic model_step(input int d);
    int x;
    x = -1;
    if (m_serving[d] && req_valid[m_g[d]]) x = m_g[d];
    m_xfer_id[d] = x;
    m_valid[d]   = (x >= 0);
    m_data[d]    = (x >= 0) ? req_data[8*x +: 8] : 8'hBC;
    if (m_sync_left[d] > 0) begin
      m_sync_left[d]--;
      if (m_sync_left[d] == 0) m_sync_done[d] = 1'b1;
    end else if (!m_serving[d]) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_ptr[d] + k) % N]) begin
          m_g[d]       = (m_ptr[d] + k) % N;
          m_beats[d]   = 0;
          m_serving[d] = 1'b1;
          break;
        end
      end
    end else if (x >= 0 && m_beats[d] + 1 < burst_of(d)) begin
      m_beats[d]++;
    end else begin
      m_serving[d] = 1'b0;
      m_ptr[d]     = (m_g[d] + 1) % N;
    end
  endtask

  always @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compare_dut(input string tag, input int d, input logic [7:0] dat, input logic vld,
                             input logic [N-1:0] rdy, input logic [1:0] gid, input logic sd);
    checkOutput({tag, ".data_inP"}, 32'(dat), 32'(m_data[d]));
    checkOutput({tag, ".valid_in"}, 32'(vld), 32'(m_valid[d]));
    checkOutput({tag, ".req_ready"}, 32'(rdy), 32'(exp_ready(d)));
    checkOutput({tag, ".grant_id"}, 32'(gid), 32'(m_g[d]));
    checkOutput({tag, ".sync_done"}, 32'(sd), 32'(m_sync_done[d]));
  endtask

  always @(negedge clk_f) begin
    if (check_en) begin
      compare_dut("A", 0, data_a, valid_a, ready_a, gid_a, sync_a);
      compare_dut("B", 1, data_b, valid_b, ready_b, gid_b, sync_b);
    end
  end

  // One cycle: advance the byte of whichever requester lane A just accepted, then drive valids for the next edge.
  task automatic applyStimulus(input logic [N-1:0] v);
    @(negedge clk_f);
    if (m_xfer_id[0] >= 0) next_byte[m_xfer_id[0]] = next_byte[m_xfer_id[0]] + 8'd1;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = next_byte[i];
    req_valid = v;
  endtask

  int         j;
  int         rr_order [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_r2 [10] = '{8'hBC, 8'h10, 8'h11, 8'h12, 8'h13, 8'hBC, 8'h14, 8'h15, 8'h16, 8'h17};

  initial begin
    for (int i = 0; i < N; i++) next_byte[i] = 8'(8'h80 + 16 * i);
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = next_byte[i];
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_data", 32'(data_a), 32'hBC);
    checkOutput("rst_valid", 32'(valid_a), 32'd0);
    checkOutput("rst_ready", 32'(ready_a), 32'd0);
    checkOutput("rst_grant", 32'(gid_a), 32'd0);
    checkOutput("rst_sync", 32'(sync_a), 32'(SYNC_RST));
    check_en  = 1'b1;
    req_valid = 4'hF;
    @(negedge clk_f);
    reset = 1'b1;

    $display("[TB] all requesters valid: preamble, first payload, grant rotation");
    for (int n = 1; n <= SYNC_OFF + 14; n++) begin
      applyStimulus(4'hF);
`ifdef PS_ARB_SYNC_EN
      if (n == SYNC_OFF - 1) begin
        checkOutput("sync_low", 32'(sync_a), 32'd0);
        checkOutput("sync_comma", 32'(data_a), 32'hBC);
      end
      if (n == SYNC_OFF) checkOutput("sync_high", 32'(sync_a), 32'd1);
`endif
      if (n == SYNC_OFF + 1) begin
        checkOutput("first_idle_valid", 32'(valid_a), 32'd0);
        checkOutput("first_grant", 32'(gid_a), 32'd0);
        checkOutput("first_ready", 32'(ready_a), 32'b0001);
      end
      if (n == SYNC_OFF + 2) begin
        checkOutput("first_payload_valid", 32'(valid_a), 32'd1);
        checkOutput("first_payload_data", 32'(data_a), 32'h80);
      end
      if (n == SYNC_OFF + 14) begin
        checkOutput("midburst_valid", 32'(valid_a), 32'd1);
        checkOutput("midburst_grant", 32'(gid_a), 32'd2);
      end
      j = n - SYNC_OFF - 2;
      if (j >= 0 && j % 3 == 0) begin
        checkOutput($sformatf("rr_grant%0d", j / 3), 32'(gid_b), 32'(rr_order[j / 3]));
        checkOutput($sformatf("rr_beat%0d", j / 3), 32'(valid_b), 32'd1);
      end
      if (j >= 2 && j % 3 == 2 && j <= 11) begin
        checkOutput($sformatf("rr_comma%0d", j / 3), 32'(valid_b), 32'd0);
        checkOutput($sformatf("rr_comma_data%0d", j / 3), 32'(data_b), 32'hBC);
      end
    end

    $display("[TB] reset asserted in the middle of a burst");
    @(posedge clk_f);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(valid_a), 32'd0);
    checkOutput("midrst_data", 32'(data_a), 32'hBC);
    checkOutput("midrst_ready", 32'(ready_a), 32'd0);
    checkOutput("midrst_ready_b", 32'(ready_b), 32'd0);
    checkOutput("midrst_grant", 32'(gid_a), 32'd0);
    checkOutput("midrst_sync", 32'(sync_a), 32'(SYNC_RST));
    next_byte[0] = 8'h60;
    applyStimulus(4'hF);
    reset = 1'b1;
    for (int n = 1; n <= SYNC_OFF + 2; n++) begin
      applyStimulus(4'hF);
`ifdef PS_ARB_SYNC_EN
      if (n == SYNC_OFF - 1) checkOutput("resync_low", 32'(sync_a), 32'd0);
`endif
      if (n == SYNC_OFF + 1) begin
        checkOutput("restart_grant", 32'(gid_a), 32'd0);
        checkOutput("restart_ready", 32'(ready_a), 32'b0001);
      end
      if (n == SYNC_OFF + 2) begin
        checkOutput("restart_valid", 32'(valid_a), 32'd1);
        checkOutput("restart_data", 32'(data_a), 32'h60);
        checkOutput("restart_grant_b", 32'(gid_b), 32'd0);
      end
    end

    $display("[TB] single requester 2 streaming");
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    next_byte[2] = 8'h10;
    applyStimulus(4'b0100);
    for (int n = 1; n <= 10; n++) begin
      applyStimulus(4'b0100);
      checkOutput($sformatf("r2_data%0d", n), 32'(data_a), 32'(exp_r2[n - 1]));
      checkOutput($sformatf("r2_valid%0d", n), 32'(valid_a), (n == 1 || n == 6) ? 32'd0 : 32'd1);
      checkOutput($sformatf("r2_grant%0d", n), 32'(gid_a), 32'd2);
    end

    $display("[TB] requester 1 drops valid after one beat");
    applyStimulus(4'b0000);
    #2 reset = 1'b0;
    next_byte[1] = 8'h20;
    next_byte[2] = 8'h30;
    applyStimulus(4'b0110);
    reset = 1'b1;
    for (int n = 1; n <= SYNC_OFF + 5; n++) begin
      applyStimulus((n >= SYNC_OFF + 2) ? 4'b0100 : 4'b0110);
      if (n == SYNC_OFF + 1) begin
        checkOutput("drop_grant1", 32'(gid_a), 32'd1);
        checkOutput("drop_ready1", 32'(ready_a), 32'b0010);
      end
      if (n == SYNC_OFF + 2) begin
        checkOutput("drop_beat_valid", 32'(valid_a), 32'd1);
        checkOutput("drop_beat_data", 32'(data_a), 32'h20);
      end
      if (n == SYNC_OFF + 3) begin
        checkOutput("drop_comma_valid", 32'(valid_a), 32'd0);
        checkOutput("drop_comma_data", 32'(data_a), 32'hBC);
        checkOutput("drop_idle_ready", 32'(ready_a), 32'd0);
        checkOutput("drop_comma_valid_b", 32'(valid_b), 32'd0);
      end
      if (n == SYNC_OFF + 4) begin
        checkOutput("drop_next_grant", 32'(gid_a), 32'd2);
        checkOutput("drop_next_ready", 32'(ready_a), 32'b0100);
        checkOutput("drop_next_grant_b", 32'(gid_b), 32'd2);
      end
      if (n == SYNC_OFF + 5) begin
        checkOutput("drop_next_valid", 32'(valid_a), 32'd1);
        checkOutput("drop_next_data", 32'(data_a), 32'h30);
      end
    end

    applyStimulus(4'b0000);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
